// File: rtl/sdclk_pkg.sv
// sdclk_pkg: shared constants, ratio type and clamp helper for the SD clock divider.
package sdclk_pkg;
  localparam int SDCLK_MIN_DIV = 2;
  localparam int SDCLK_DIV_W = 10;
  localparam int SDCLK_RESET_DIV = 250;
  typedef logic [SDCLK_DIV_W-1:0] sddiv_t;
  function automatic sddiv_t clamp_div(input sddiv_t div);
    return (div < sddiv_t'(SDCLK_MIN_DIV)) ? sddiv_t'(SDCLK_MIN_DIV) : div;
  endfunction
endpackage

// File: rtl/sd_clkdiv_gen.sv
// sd_clkdiv_gen: SD clock divider with ratio handshake and edge strobes.
// Define SDCLKGEN_STOP_EN to enable parking sdclk low at a period boundary.
module sd_clkdiv_gen
  import sdclk_pkg::*;
#(
  parameter int DIV_W = SDCLK_DIV_W,
  parameter int RESET_DIV = SDCLK_RESET_DIV
) (
  input  logic             sdctrl_clock_i,
  input  logic             sdctrl_reset_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic [DIV_W-1:0] div_o,
  input  logic             stop_req_i,
  output logic             stopped_o,
  output logic             sdclk_o,
  output logic             rise_stb_o,
  output logic             fall_stb_o
);
  logic [DIV_W-1:0] r_cnt, r_div, w_half, w_last, w_new_div, w_div_n, w_cnt_n;
  logic r_stopped, r_sdclk, w_stop, w_bnd, w_stopped_n, w_sdclk_n;
`ifdef SDCLKGEN_STOP_EN
  assign w_stop = stop_req_i;
`else
  logic w_unused_stop;
  assign w_unused_stop = stop_req_i;
  assign w_stop = 1'b0;
`endif
  assign w_half = r_div >> 1;
  assign w_last = r_div - 1'b1;
  assign w_bnd = (r_cnt == w_last) || r_stopped;
  assign w_new_div = (div_i < DIV_W'(SDCLK_MIN_DIV)) ? DIV_W'(SDCLK_MIN_DIV) : div_i;
  assign w_div_n = (div_valid_i && w_bnd) ? w_new_div : r_div;
  assign w_stopped_n = w_bnd && w_stop;
  // A stopped divider holds its count; resuming always starts a fresh period at cnt 0.
  assign w_cnt_n = w_stopped_n ? r_cnt : w_bnd ? '0 : r_cnt + 1'b1;
  assign w_sdclk_n = !w_stopped_n && (w_cnt_n < (w_div_n >> 1));
  always_ff @(posedge sdctrl_clock_i or posedge sdctrl_reset_i) begin
    if (sdctrl_reset_i) begin
      r_cnt <= DIV_W'(RESET_DIV - 1);
      r_div <= DIV_W'(RESET_DIV);
      r_stopped <= 1'b0;
      r_sdclk <= 1'b0;
    end else begin
      r_cnt <= w_cnt_n;
      r_div <= w_div_n;
      r_stopped <= w_stopped_n;
      r_sdclk <= w_sdclk_n;
    end
  end
  assign div_o = r_div;
  assign stopped_o = r_stopped;
  assign sdclk_o = r_sdclk;
  assign div_ready_o = w_bnd && !sdctrl_reset_i;
  assign rise_stb_o = w_bnd && !w_stop && !sdctrl_reset_i;
  assign fall_stb_o = (r_cnt == w_half - 1'b1) && !r_stopped && !sdctrl_reset_i;
endmodule
